// File: rtl/vector_perm_unit_pkg.sv
// Shared types and decode helpers for the cross-lane permutation responder.
package vector_perm_unit_pkg;

  // Decoded permutation opcode; PERM_NONE marks an idle cycle.
  typedef enum logic [2:0] {
    PERM_NONE,
    PERM_SLIDEUP,
    PERM_SLIDEDOWN,
    PERM_GATHER,
    PERM_GROUP
  } perm_op_e;

  // op_bits is {group, gather, slidedown, slideup}; the lowest set bit wins.
  function automatic perm_op_e perm_decode(input logic [3:0] op_bits);
    if (op_bits[0])      return PERM_SLIDEUP;
    else if (op_bits[1]) return PERM_SLIDEDOWN;
    else if (op_bits[2]) return PERM_GATHER;
    else if (op_bits[3]) return PERM_GROUP;
    else                 return PERM_NONE;
  endfunction

  // True when more than one op bit is set.
  function automatic logic perm_multi_hot(input logic [3:0] op_bits);
    return (op_bits & (op_bits - 4'd1)) != 4'd0;
  endfunction

endpackage

// File: rtl/vperm_compress.sv
// Combinational compress packer: active bytes are packed in ascending order from byte 0.
module vperm_compress #(
  parameter int NB = 32,
  parameter int CW = $clog2(NB + 1)
) (
  input  logic [NB*8-1:0] data_in,
  input  logic [NB-1:0]   mask_in,
  output logic [NB*8-1:0] packed_data,
  output logic [CW-1:0]   packed_count
);

  int active_below;

  // Each active byte lands at the running count of active bytes below it.
  always_comb begin
    packed_data  = '0;
    active_below = 0;
    for (int b = 0; b < NB; b++) begin
      if (mask_in[b]) begin
        packed_data[active_below*8 +: 8] = data_in[b*8 +: 8];
        active_below = active_below + 1;
      end
    end
    packed_count = CW'(active_below);
  end

endmodule

// File: rtl/vector_perm_unit.sv
// Cross-lane permutation responder: treats all lanes as one wide register and
// returns slide-up, slide-down, gather or compress results two cycles after a request.
module vector_perm_unit
  import vector_perm_unit_pkg::*;
#(
  parameter int VECTOR_LANES = 4,
  parameter int DATA_WIDTH   = 64
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [VECTOR_LANES-1:0]            lane_perm_slideup,
  input  logic [VECTOR_LANES-1:0]            lane_perm_slidedown,
  input  logic [VECTOR_LANES-1:0]            lane_perm_gather,
  input  logic [VECTOR_LANES-1:0]            lane_perm_group,
  input  logic [VECTOR_LANES*DATA_WIDTH-1:0] lane_perm_input,
  input  logic [VECTOR_LANES*DATA_WIDTH-1:0] lane_perm_vector,
  input  logic [VECTOR_LANES*DATA_WIDTH-1:0] lane_perm_scalar,
  input  logic [VECTOR_LANES*DATA_WIDTH/8-1:0] lane_perm_mask,
  output logic [VECTOR_LANES*DATA_WIDTH-1:0] lane_perm_result,
  output logic                               perm_valid,
  output logic                               perm_conflict
);

  localparam int W  = VECTOR_LANES * DATA_WIDTH;
  localparam int NB = W / 8;
  localparam int OW = $clog2(NB + 1);
  localparam int IW = $clog2(NB);

  // Stage 1 request: offsets are saturated to NB so the datapath never sees more.
  typedef struct packed {
    perm_op_e        op;
    logic [W-1:0]    input_data;
    logic [W-1:0]    vector_data;
    logic [NB-1:0]   mask;
    logic [OW-1:0]   offset;
    logic            conflict;
  } perm_req_t;

  logic [3:0]            lead_ops;
  logic                  req_valid;
  perm_req_t             req_next;
  logic [DATA_WIDTH-1:0] lead_scalar;
  logic                  unused_scalar;

  logic                  s1_valid;
  perm_req_t             s1;

  logic [NB-1:0][7:0]    src_bytes;
  logic [NB-1:0][7:0]    old_bytes;
  logic [NB-1:0][7:0]    grp_bytes;
  logic [NB-1:0][7:0]    res_next;
  logic [W-1:0]          grp_data;
  logic [OW-1:0]         grp_count;
  logic [7:0]            pick;

  // Only lane 0's scalar carries the offset; the rest are ignored.
  assign lead_scalar   = lane_perm_scalar[DATA_WIDTH-1:0];
  assign unused_scalar = ^lane_perm_scalar;

  // Lane 0 decides the op; any disagreement or multi-hot lane 0 is flagged.
  always_comb begin
    lead_ops  = {lane_perm_group[0], lane_perm_gather[0],
                 lane_perm_slidedown[0], lane_perm_slideup[0]};
    req_valid = |lead_ops;
    req_next.op          = perm_decode(lead_ops);
    req_next.input_data  = lane_perm_input;
    req_next.vector_data = lane_perm_vector;
    req_next.mask        = lane_perm_mask;
    req_next.conflict    = perm_multi_hot(lead_ops);
    for (int i = 0; i < VECTOR_LANES; i++) begin
      if ({lane_perm_group[i], lane_perm_gather[i],
           lane_perm_slidedown[i], lane_perm_slideup[i]} != lead_ops)
        req_next.conflict = 1'b1;
    end
    if (lead_scalar >= DATA_WIDTH'(NB))
      req_next.offset = OW'(NB);
    else
      req_next.offset = lead_scalar[OW-1:0];
  end

  // Stage 1 register: capture the decoded request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else begin
      s1_valid <= req_valid;
      s1       <= req_next;
    end
  end

  assign src_bytes = s1.input_data;
  assign old_bytes = s1.vector_data;
  assign grp_bytes = grp_data;

  vperm_compress #(.NB(NB), .CW(OW)) u_compress (
    .data_in      (s1.input_data),
    .mask_in      (s1.mask),
    .packed_data  (grp_data),
    .packed_count (grp_count)
  );

  // Per-byte result; inactive bytes keep the old destination byte.
  always_comb begin
    res_next = old_bytes;
    pick     = 8'h00;
    for (int b = 0; b < NB; b++) begin
      case (s1.op)
        PERM_SLIDEUP:
          pick = (b < int'(s1.offset)) ? old_bytes[b]
                                       : src_bytes[IW'(b - int'(s1.offset))];
        PERM_SLIDEDOWN:
          pick = (b + int'(s1.offset) < NB) ? src_bytes[IW'(b + int'(s1.offset))]
                                            : 8'h00;
        PERM_GATHER:
          pick = (int'(old_bytes[b]) < NB) ? src_bytes[IW'(old_bytes[b])] : 8'h00;
        PERM_GROUP:
          pick = (b < int'(grp_count)) ? grp_bytes[b] : old_bytes[b];
        default:
          pick = old_bytes[b];
      endcase
      if (s1.op != PERM_GROUP && !s1.mask[b])
        pick = old_bytes[b];
      res_next[b] = pick;
    end
  end

  // Stage 2 register: result holds between requests, flags pulse with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_perm_result <= '0;
      perm_valid       <= 1'b0;
      perm_conflict    <= 1'b0;
    end else begin
      perm_valid    <= s1_valid;
      perm_conflict <= s1_valid & s1.conflict;
      if (s1_valid)
        lane_perm_result <= res_next;
    end
  end

endmodule
